uart_sample_deframer: RTL and testbench

Consumes the byte stream from the UART receiver (8-bit data plus a one-cycle valid pulse) and parses framed packets of 16-bit signed samples. Each sample goes into an internal FIFO, which drives the digital filter input through a valid/ready interface. Each frame end reports a checksum and length status.

---
 rtl/uart_frame_pkg.sv | 27 ++
 rtl/uart_sample_deframer_if.sv | 20 ++
 rtl/uart_sample_deframer_sample_fifo.sv | 60 ++++++
 rtl/uart_sample_deframer.sv | 170 +++++++++++++++++
 tb/tb_uart_sample_deframer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared types and constants for the UART sample deframer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    LEN  = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    CSUM = 3'd4
  } deframe_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/uart_sample_deframer_if.sv
// ============================================================================
// Module      : uart_sample_deframer_if
// Description : Byte-in / sample-out stream bundle of the deframer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_sample_deframer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;

  // master is the deframer side, slave is the byte source / sample sink
  modport master (input rx_data, rx_valid, m_ready, output m_data, m_valid);
  modport slave  (output rx_data, rx_valid, m_ready, input m_data, m_valid);
endinterface

`default_nettype wire

// File: rtl/uart_sample_deframer_sample_fifo.sv
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous first-word-fall-through FIFO, data reads zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     wr_en,
  input  wire logic [WIDTH-1:0]         wr_data,
  output logic                          full,
  input  wire logic                     rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_fire;
  logic             wr_fire;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign rd_fire = rd_en & ~empty;
  // a write into a full FIFO only lands when a read frees a slot on the same edge
  assign wr_fire = wr_en & (~full | rd_fire);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_fire, rd_fire})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_sample_deframer.sv
// ============================================================================
// Module      : uart_sample_deframer
// Description : Parses SYNC/LEN/payload/CSUM byte frames into 16-bit samples.
//               Optional inter-byte timeout: define UART_DEFRAMER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sample_deframer
  import uart_frame_pkg::*;
#(
  parameter int         MAX_SAMPLES  = 64,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  uart_sample_deframer_if.master           stream,
  output logic                             frame_done,
  output logic                             frame_ok,
  output logic [1:0]                       err_code,
  output logic                             overflow,
  input  wire logic                        clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_SAMPLES);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (MAX_SAMPLES < 1 || MAX_SAMPLES > 255) begin : g_bad_max
    $error("MAX_SAMPLES must be in 1..255");
  end
  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be >= 2");
  end

  deframe_state_t state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     acc_q, acc_d;
  logic [7:0]     lo_q, lo_d;
  logic           push;
  logic           done_d, ok_d;
  logic [1:0]     err_d;
  logic           timeout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           rd_xfer;
  logic           ovf_set;

`ifdef UART_DEFRAMER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CLKS);
  logic [IDLE_W-1:0] idle_q;

  assign timeout = (state_q != HUNT) && (idle_q == IDLE_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if (state_q == HUNT || stream.rx_valid || timeout) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IDLE_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    push    = 1'b0;
    done_d  = 1'b0;
    ok_d    = frame_ok;
    err_d   = err_code;
    // timeout wins over a byte arriving on the same cycle
    if (timeout) begin
      state_d = HUNT;
      done_d  = 1'b1;
      ok_d    = 1'b0;
      err_d   = ERR_TIMEOUT;
    end else if (stream.rx_valid) begin
      unique case (state_q)
        HUNT: begin
          if (stream.rx_data == SYNC_BYTE) state_d = LEN;
        end
        LEN: begin
          if (stream.rx_data == 8'd0 || stream.rx_data > MAX_LEN) begin
            state_d = HUNT;
            done_d  = 1'b1;
            ok_d    = 1'b0;
            err_d   = ERR_LEN;
          end else begin
            cnt_d   = stream.rx_data;
            acc_d   = stream.rx_data;
            state_d = LO;
          end
        end
        LO: begin
          lo_d    = stream.rx_data;
          acc_d   = acc_q ^ stream.rx_data;
          state_d = HI;
        end
        HI: begin
          push    = 1'b1;
          acc_d   = acc_q ^ stream.rx_data;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? CSUM : LO;
        end
        CSUM: begin
          done_d  = 1'b1;
          ok_d    = (stream.rx_data == acc_q);
          err_d   = ok_d ? ERR_NONE : ERR_CSUM;
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign rd_xfer        = stream.m_valid & stream.m_ready;
  assign ovf_set        = push & fifo_full & ~rd_xfer;
  assign stream.m_valid = ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= ERR_NONE;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      frame_done <= done_d;
      frame_ok   <= ok_d;
      err_code   <= err_d;
      if (ovf_set)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  sample_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({stream.rx_data, lo_q}),
    .full    (fifo_full),
    .rd_en   (stream.m_ready),
    .rd_data (stream.m_data),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_sample_deframer.sv
// ============================================================================
// Module      : tb_uart_sample_deframer
// Description : Self-checking bench: vector table, corner sequences, random frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_sample_deframer;
  import uart_frame_pkg::*;

  localparam int MAXS  = 64;
  localparam int DEPTH = 16;
`ifdef UART_DEFRAMER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 50000;
`endif

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] sq_t[$];

  typedef struct {
    logic [95:0] b;
    int          n;
    int          nsamp;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [2:0]  st;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_sample_deframer_if bus ();
  logic                   frame_done, frame_ok, overflow, clr_overflow;
  logic [1:0]             err_code;
  logic [$clog2(DEPTH):0] fifo_level;

  uart_sample_deframer #(
    .MAX_SAMPLES  (MAXS),
    .FIFO_DEPTH   (DEPTH),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stream       (bus),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .err_code     (err_code),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .fifo_level   (fifo_level)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] got_s[$];
  logic [2:0]  got_st[$];
  logic        rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) got_s.push_back(bus.m_data);
      if (frame_done) got_st.push_back({frame_ok, err_code});
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 bus.m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input bq_t q, input int maxgap);
    foreach (q[k]) begin
      send_byte(q[k]);
      idle($urandom_range(0, maxgap));
    end
  endtask

  // Frame built straight from the format rule: SYNC, LEN, lo/hi pairs, XOR checksum
  function automatic bq_t build_frame(input sq_t s, input bit corrupt);
    bq_t        q;
    logic [7:0] cs;
    q.push_back(8'hA5);
    q.push_back(8'(s.size()));
    cs = 8'(s.size());
    foreach (s[k]) begin
      q.push_back(s[k][7:0]);
      q.push_back(s[k][15:8]);
      cs = cs ^ s[k][7:0] ^ s[k][15:8];
    end
    if (corrupt) cs = cs ^ (8'(1) << $urandom_range(0, 7));
    q.push_back(cs);
    return q;
  endfunction

  vec_t       vt[6];
  sq_t        s;
  sq_t        exp_s;
  logic [2:0] exp_st[$];
  bq_t        fb;
  int         errs;
  int         k;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{96'hA5_02_34_12_CD_AB_42, 7, 2, 16'h1234, 16'hABCD, 3'b100};
    vt[1] = '{96'hA5_02_34_12_CD_AB_41, 7, 2, 16'h1234, 16'hABCD, 3'b001};
    vt[2] = '{96'h00_FF_5A_A5_00,       5, 0, 16'h0,    16'h0,    3'b010};
    vt[3] = '{96'hA5_41,                2, 0, 16'h0,    16'h0,    3'b010};
    vt[4] = '{96'hA5_01_EF_BE_50,       5, 1, 16'hBEEF, 16'h0,    3'b100};
    vt[5] = '{96'hA5_01_A5_A5_01,       5, 1, 16'hA5A5, 16'h0,    3'b100};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.m_ready  = 1'b1;
    clr_overflow = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_err_code", err_code, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    rst = 1'b0;
    idle(2);

    // vector table, bytes back-to-back
    for (int i = 0; i < 6; i++) begin
      got_s.delete();
      got_st.delete();
      for (int j = 0; j < vt[i].n; j++) send_byte(vt[i].b[8*(vt[i].n-1-j) +: 8]);
      idle(4);
      check("vec_ndone", got_st.size(), 1);
      if (got_st.size() > 0) check("vec_status", got_st[0], vt[i].st);
      check("vec_held", {frame_ok, err_code}, vt[i].st);
      check("vec_nsamp", got_s.size(), vt[i].nsamp);
      if (vt[i].nsamp > 0 && got_s.size() > 0) check("vec_s0", got_s[0], vt[i].s0);
      if (vt[i].nsamp > 1 && got_s.size() > 1) check("vec_s1", got_s[1], vt[i].s1);
    end

    // overflow: 20 samples into a 16-deep FIFO with the sink stalled
    bus.m_ready = 1'b0;
    got_s.delete();
    got_st.delete();
    s.delete();
    for (int i = 0; i < 20; i++) s.push_back(16'($urandom));
    fb = build_frame(s, 1'b0);
    for (int j = 0; j < fb.size(); j++) begin
      send_byte(fb[j]);
      if (j == 2) check("lat_before_hi", bus.m_valid, 0);
      if (j == 3) begin
        check("lat_after_hi", bus.m_valid, 1);
        check("lat_m_data", bus.m_data, s[0]);
      end
    end
    idle(2);
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_flag", overflow, 1);
    check("ovf_status", {frame_ok, err_code}, 3'b100);
    check("ovf_no_pop", got_s.size(), 0);
    bus.m_ready = 1'b1;
    idle(20);
    check("ovf_drain_n", got_s.size(), DEPTH);
    errs = 0;
    for (int i = 0; i < DEPTH && i < got_s.size(); i++) if (got_s[i] !== s[i]) errs++;
    check("ovf_drain_order", errs, 0);
    check("ovf_drain_level", fifo_level, 0);
    check("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);

    // asynchronous reset mid-payload
    bus.m_ready = 1'b0;
    got_st.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD);
    check("mid_level_pre", fifo_level, 1);
    rst = 1'b1;
    #2;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_m_valid", bus.m_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    got_s.delete();
    idle(2);
    send_byte(8'hAB); send_byte(8'h42); send_byte(8'h01); send_byte(8'h34);
    for (int j = 0; j < vt[0].n; j++) send_byte(vt[0].b[8*(vt[0].n-1-j) +: 8]);
    idle(4);
    check("mid_ndone", got_st.size(), 1);
    if (got_st.size() > 0) check("mid_status", got_st[0], 3'b100);
    check("mid_nsamp", got_s.size(), 2);

    // largest legal LEN
    got_s.delete();
    got_st.delete();
    s.delete();
    for (int i = 0; i < MAXS; i++) s.push_back(16'($urandom));
    send_bytes(build_frame(s, 1'b0), 0);
    idle(4);
    check("max_nsamp", got_s.size(), MAXS);
    errs = 0;
    for (int i = 0; i < MAXS && i < got_s.size(); i++) if (got_s[i] !== s[i]) errs++;
    check("max_order", errs, 0);
    check("max_status", {frame_ok, err_code}, 3'b100);

    // random frames against the reference model
    got_s.delete();
    got_st.delete();
    exp_s.delete();
    exp_st.delete();
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      k = $urandom_range(0, 3);
      repeat (k) begin
        logic [7:0] nz;
        nz = 8'($urandom);
        if (nz == 8'hA5) nz = 8'h5A;
        send_byte(nz);
      end
      if ($urandom_range(0, 5) == 0) begin
        fb.delete();
        fb.push_back(8'hA5);
        fb.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXS + 1, 255)));
        send_bytes(fb, 2);
        exp_st.push_back({1'b0, ERR_LEN});
      end else begin
        bit bad;
        s.delete();
        k = $urandom_range(1, 8);
        for (int i = 0; i < k; i++) s.push_back(16'($urandom));
        bad = ($urandom_range(0, 3) == 0);
        send_bytes(build_frame(s, bad), 2);
        foreach (s[i]) exp_s.push_back(s[i]);
        exp_st.push_back(bad ? {1'b0, ERR_CSUM} : {1'b1, ERR_NONE});
      end
    end
    rand_ready = 1'b0;
    idle(2);
    bus.m_ready = 1'b1;
    idle(30);
    check("rnd_ndone", got_st.size(), exp_st.size());
    errs = 0;
    for (int i = 0; i < exp_st.size() && i < got_st.size(); i++) if (got_st[i] !== exp_st[i]) errs++;
    check("rnd_status", errs, 0);
    check("rnd_nsamp", got_s.size(), exp_s.size());
    errs = 0;
    for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) if (got_s[i] !== exp_s[i]) errs++;
    check("rnd_samples", errs, 0);
    check("rnd_overflow", overflow, 0);

`ifdef UART_DEFRAMER_TIMEOUT_EN
    got_st.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34);
    k = 0;
    while (k < 300 && !frame_done) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tmo_cycles", k, TMO);
    check("tmo_status", {frame_ok, err_code}, {1'b0, ERR_TIMEOUT});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
